dsp_slice_param: RTL and testbench

- Parametrised fixed-point DSP slice: next generation of the team's 18x19 slice.
- Two channels (a, b). Each channel has a pre-adder (y±z) feeding a multiplier. Multiplier operand is either the x input or an entry from a runtime-writable coefficient bank.
- Products feed either independent saturated outputs or a shared 64-bit accumulator with constant-load, negate, chain input and optional saturation.
- Sits in datapath arrays; chainout feeds the next slice's chainin.

---
 rtl/dsp_slice_param.sv | 202 ++++++++++++++++++++
 tb/tb_dsp_slice_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_slice_param.sv
// Two-channel pre-add/multiply slice with runtime coefficient banks and a shared
// cascadable accumulator. Three enabled pipeline stages from sample to result.
module dsp_slice_param #(
  parameter int AW_Y       = 19,
  parameter int AW_Z       = 18,
  parameter int AW_X       = 18,
  parameter int COEF_DEPTH = 8,
  parameter int RES_W      = 37,
  parameter int ACC_W      = 64,
  parameter int SAT_EN     = 1,
  localparam int CSEL_W    = (COEF_DEPTH > 1) ? $clog2(COEF_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [AW_Y-1:0]   ay,
  input  logic signed [AW_Y-1:0]   by,
  input  logic signed [AW_Z-1:0]   az,
  input  logic signed [AW_Z-1:0]   bz,
  input  logic signed [AW_X-1:0]   ax,
  input  logic signed [AW_X-1:0]   bx,
  input  logic                     sub_a,
  input  logic                     sub_b,
  input  logic                     coefmux_a,
  input  logic                     coefmux_b,
  input  logic [CSEL_W-1:0]        coefsel_a,
  input  logic [CSEL_W-1:0]        coefsel_b,
  input  logic [1:0]               func,
  input  logic                     accumulate,
  input  logic                     loadconst,
  input  logic                     negate,
  input  logic signed [ACC_W-1:0]  constant,
  input  logic signed [ACC_W-1:0]  chainin,
  input  logic                     coef_wr_en,
  input  logic                     coef_wr_ch,
  input  logic [CSEL_W-1:0]        coef_wr_addr,
  input  logic signed [AW_X-1:0]   coef_wr_data,
  output logic                     out_valid,
  output logic [RES_W-1:0]         resulta,
  output logic [RES_W-1:0]         resultb,
  output logic [ACC_W-1:0]         chainout,
  output logic                     overflow
);

  localparam int PRE_W = AW_Y + 1;
  localparam int PW    = PRE_W + AW_X;
  localparam int SW    = ACC_W + 1;
  localparam int NW    = ACC_W + 2;

  localparam logic [RES_W-1:0] RES_MAX = {1'b0, {(RES_W-1){1'b1}}};
  localparam logic [RES_W-1:0] RES_MIN = {1'b1, {(RES_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PW-1:0]    w_prod [2];
  logic [RES_W-1:0]        w_sat  [2];
  logic [1:0]              w_clamp;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [AW_Y-1:0]  w_y;
      logic signed [AW_Z-1:0]  w_z;
      logic signed [AW_X-1:0]  w_x;
      logic                    w_sub;
      logic                    w_cmux;
      logic [CSEL_W-1:0]       w_csel;
      logic signed [AW_X-1:0]  r_bank [COEF_DEPTH];
      logic signed [PRE_W-1:0] r_pre;
      logic signed [AW_X-1:0]  r_opnd;
      logic signed [PW-1:0]    r_prod;

      assign w_y    = (gi == 0) ? ay        : by;
      assign w_z    = (gi == 0) ? az        : bz;
      assign w_x    = (gi == 0) ? ax        : bx;
      assign w_sub  = (gi == 0) ? sub_a     : sub_b;
      assign w_cmux = (gi == 0) ? coefmux_a : coefmux_b;
      assign w_csel = (gi == 0) ? coefsel_a : coefsel_b;

      // Bank writes ignore en so coefficients can be reloaded while the pipe is stalled.
      always_ff @(posedge clk) begin
        if (!clr_n) begin
          for (int k = 0; k < COEF_DEPTH; k++) r_bank[k] <= '0;
        end else if (coef_wr_en && (coef_wr_ch == 1'(gi))) begin
          r_bank[coef_wr_addr] <= coef_wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!clr_n) begin
          r_pre  <= '0;
          r_opnd <= '0;
          r_prod <= '0;
        end else if (en) begin
          r_pre  <= w_sub ? (PRE_W'(w_y) - PRE_W'(w_z)) : (PRE_W'(w_y) + PRE_W'(w_z));
          r_opnd <= w_cmux ? r_bank[w_csel] : w_x;
          r_prod <= PW'(r_pre) * PW'(r_opnd);
        end
      end

      assign w_prod[gi] = r_prod;

      if (RES_W >= PW) begin : g_nosat
        assign w_sat[gi]   = RES_W'(r_prod);
        assign w_clamp[gi] = 1'b0;
      end else begin : g_sat
        logic [PW-RES_W:0] w_top;
        assign w_top       = r_prod[PW-1:RES_W-1];
        assign w_clamp[gi] = !((&w_top) || !(|w_top));
        assign w_sat[gi]   = w_clamp[gi] ? (r_prod[PW-1] ? RES_MIN : RES_MAX)
                                         : r_prod[RES_W-1:0];
      end
    end
  endgenerate

  // Per-sample controls ride alongside the datapath through S1 and S2.
  logic                    r1_valid, r2_valid;
  logic [1:0]              r1_func, r2_func;
  logic                    r1_acc, r2_acc, r1_lc, r2_lc, r1_neg, r2_neg;
  logic signed [ACC_W-1:0] r1_const, r2_const, r1_chain, r2_chain;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r1_valid <= 1'b0; r2_valid <= 1'b0;
      r1_func  <= '0;   r2_func  <= '0;
      r1_acc   <= 1'b0; r2_acc   <= 1'b0;
      r1_lc    <= 1'b0; r2_lc    <= 1'b0;
      r1_neg   <= 1'b0; r2_neg   <= 1'b0;
      r1_const <= '0;   r2_const <= '0;
      r1_chain <= '0;   r2_chain <= '0;
    end else if (en) begin
      r1_valid <= in_valid;   r2_valid <= r1_valid;
      r1_func  <= func;       r2_func  <= r1_func;
      r1_acc   <= accumulate; r2_acc   <= r1_acc;
      r1_lc    <= loadconst;  r2_lc    <= r1_lc;
      r1_neg   <= negate;     r2_neg   <= r1_neg;
      r1_const <= constant;   r2_const <= r1_const;
      r1_chain <= chainin;    r2_chain <= r1_chain;
    end
  end

  logic signed [ACC_W-1:0]      r_acc;
  logic [RES_W-1:0]             r_resa, r_resb;
  logic                         r_ovf, r_out_valid;
  logic signed [SW-1:0]         w_s;
  logic signed [ACC_W-1:0]      w_fb;
  logic signed [NW-1:0]         w_sum;
  logic                         w_acc_ovf;
  logic [ACC_W-1:0]             w_acc_fin;
  logic signed [ACC_W-RES_W-1:0] w_hi;
  logic                         w_keep_ovf;

  always_comb begin
    w_s = SW'(w_prod[0]) + SW'(w_prod[1]);
    case (r2_func)
      2'b10:   w_s = SW'(w_prod[0]) + SW'(w_prod[1]) + SW'(r2_chain);
      2'b11:   w_s = SW'(w_prod[0]) - SW'(w_prod[1]);
      default: w_s = SW'(w_prod[0]) + SW'(w_prod[1]);
    endcase
  end

  assign w_fb      = r2_lc ? r2_const : (r2_acc ? r_acc : '0);
  assign w_sum     = NW'(w_fb) + (r2_neg ? -NW'(w_s) : NW'(w_s));
  // Result fits ACC_W only if the three top bits agree.
  assign w_acc_ovf = !((&w_sum[NW-1:ACC_W-1]) || !(|w_sum[NW-1:ACC_W-1]));
  assign w_acc_fin = (w_acc_ovf && (SAT_EN != 0)) ? (w_sum[NW-1] ? ACC_MIN : ACC_MAX)
                                                  : w_sum[ACC_W-1:0];
  assign w_hi       = w_acc_fin[ACC_W-1:RES_W];
  assign w_keep_ovf = r_ovf && (r2_acc || r2_lc);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_resa      <= '0;
      r_resb      <= '0;
      r_ovf       <= 1'b0;
    end else if (en) begin
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        if (r2_func == 2'b00) begin
          r_resa <= w_sat[0];
          r_resb <= w_sat[1];
          r_ovf  <= (|w_clamp) || w_keep_ovf;
        end else begin
          r_acc  <= w_acc_fin;
          r_resa <= w_acc_fin[RES_W-1:0];
          r_resb <= RES_W'(w_hi);
          r_ovf  <= w_acc_ovf || w_keep_ovf;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign resulta   = r_resa;
  assign resultb   = r_resb;
  assign chainout  = r_acc;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_dsp_slice_param.sv
// Scoreboard bench for dsp_slice_param: a wide-integer model predicts each
// sample's outputs when it is driven; the monitor compares them on out_valid.
module tb_dsp_slice_param;

  localparam int AW_Y = 19, AW_Z = 18, AW_X = 18, COEF_DEPTH = 8;
  localparam int RES_W = 37, ACC_W = 64, SAT_EN = 1, CSEL_W = 3;

  logic clk = 1'b0;
  logic clr_n, en, in_valid;
  logic signed [AW_Y-1:0] ay, by;
  logic signed [AW_Z-1:0] az, bz;
  logic signed [AW_X-1:0] ax, bx;
  logic sub_a, sub_b, coefmux_a, coefmux_b;
  logic [CSEL_W-1:0] coefsel_a, coefsel_b;
  logic [1:0] func;
  logic accumulate, loadconst, negate;
  logic signed [ACC_W-1:0] constant, chainin;
  logic coef_wr_en, coef_wr_ch;
  logic [CSEL_W-1:0] coef_wr_addr;
  logic signed [AW_X-1:0] coef_wr_data;
  logic out_valid;
  logic [RES_W-1:0] resulta, resultb;
  logic [ACC_W-1:0] chainout;
  logic overflow;

  dsp_slice_param #(
    .AW_Y(AW_Y), .AW_Z(AW_Z), .AW_X(AW_X), .COEF_DEPTH(COEF_DEPTH),
    .RES_W(RES_W), .ACC_W(ACC_W), .SAT_EN(SAT_EN)
  ) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .in_valid(in_valid),
    .ay(ay), .by(by), .az(az), .bz(bz), .ax(ax), .bx(bx),
    .sub_a(sub_a), .sub_b(sub_b), .coefmux_a(coefmux_a), .coefmux_b(coefmux_b),
    .coefsel_a(coefsel_a), .coefsel_b(coefsel_b), .func(func),
    .accumulate(accumulate), .loadconst(loadconst), .negate(negate),
    .constant(constant), .chainin(chainin),
    .coef_wr_en(coef_wr_en), .coef_wr_ch(coef_wr_ch),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .out_valid(out_valid), .resulta(resulta), .resultb(resultb),
    .chainout(chainout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
  endtask

  typedef struct {
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] co;
    logic        ov;
    int          due;
  } exp_t;
  exp_t sbq[$];

  logic signed [127:0] m_acc;
  logic                m_ovf;
  logic signed [AW_X-1:0] m_bank [2][COEF_DEPTH];

  task automatic model_reset();
    m_acc = '0;
    m_ovf = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < COEF_DEPTH; k++) m_bank[c][k] = '0;
  endtask

  function automatic logic signed [127:0] clamp_res(input logic signed [127:0] v, output logic c);
    logic signed [127:0] mx, mn;
    mx = (128'sd1 <<< (RES_W-1)) - 128'sd1;
    mn = -(128'sd1 <<< (RES_W-1));
    c = 1'b0;
    if (v > mx) begin c = 1'b1; return mx; end
    if (v < mn) begin c = 1'b1; return mn; end
    return v;
  endfunction

  int  ecnt = 0;
  logic en_edge = 1'b0;

  always @(posedge clk) begin
    en_edge = (en === 1'b1) && (clr_n === 1'b1);
    if (en_edge) ecnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (en_edge && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        check("latency", 64'(ecnt), 64'(e.due));
        check("resulta", 64'(resulta), e.ra);
        check("resultb", 64'(resultb), e.rb);
        check("chainout", chainout, e.co);
        check("overflow", 64'(overflow), 64'(e.ov));
        $display("txn ra=0x%h rb=0x%h chainout=0x%h ovf=%0d", resulta, resultb, chainout, overflow);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Predict outputs for the sample currently on the inputs, then clock it in.
  task automatic fire();
    logic signed [127:0] y, z, pre, op, pa, pb, s, fb, n, lo, hi;
    logic ca, cb, ov_now;
    exp_t e;
    y = ay; z = az; pre = sub_a ? y - z : y + z;
    op = coefmux_a ? m_bank[0][coefsel_a] : ax;
    pa = pre * op;
    y = by; z = bz; pre = sub_b ? y - z : y + z;
    op = coefmux_b ? m_bank[1][coefsel_b] : bx;
    pb = pre * op;
    if (func == 2'b00) begin
      lo = clamp_res(pa, ca);
      hi = clamp_res(pb, cb);
      ov_now = ca | cb;
      e.ra = {27'd0, lo[RES_W-1:0]};
      e.rb = {27'd0, hi[RES_W-1:0]};
    end else begin
      fb = chainin;
      case (func)
        2'b10:   s = pa + pb + fb;
        2'b11:   s = pa - pb;
        default: s = pa + pb;
      endcase
      fb = loadconst ? 128'(constant) : (accumulate ? m_acc : 128'sd0);
      n = fb + (negate ? -s : s);
      ov_now = 1'b0;
      if (n > 128'sh7FFF_FFFF_FFFF_FFFF) begin n = 128'sh7FFF_FFFF_FFFF_FFFF; ov_now = 1'b1; end
      if (n < -(128'sd1 <<< 63)) begin n = -(128'sd1 <<< 63); ov_now = 1'b1; end
      m_acc = n;
      hi = n >>> RES_W;
      e.ra = {27'd0, n[RES_W-1:0]};
      e.rb = {27'd0, hi[RES_W-1:0]};
    end
    m_ovf = ov_now | (m_ovf & (accumulate | loadconst));
    e.co  = m_acc[63:0];
    e.ov  = m_ovf;
    e.due = ecnt + 3;
    sbq.push_back(e);
    if (coef_wr_en) m_bank[coef_wr_ch][coef_wr_addr] = coef_wr_data;
    in_valid = 1'b1;
    step(1);
    in_valid   = 1'b0;
    coef_wr_en = 1'b0;
  endtask

  task automatic wr_coef(input logic ch, input logic [CSEL_W-1:0] addr, input logic signed [AW_X-1:0] data);
    coef_wr_en = 1'b1; coef_wr_ch = ch; coef_wr_addr = addr; coef_wr_data = data;
    step(1);
    coef_wr_en = 1'b0;
    m_bank[ch][addr] = data;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step(1);
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_resa"}, 64'(resulta), 64'd0);
    check({tag, "_resb"}, 64'(resultb), 64'd0);
    check({tag, "_chain"}, chainout, 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    logic [63:0] co_hold;
    logic        ov_hold;
    clr_n = 1'b0; en = 1'b1; in_valid = 1'b0;
    ay = 1; az = 2; ax = 3; by = 4; bz = 5; bx = 6;
    sub_a = 0; sub_b = 0; coefmux_a = 0; coefmux_b = 0; coefsel_a = 0; coefsel_b = 0;
    func = 2'b00; accumulate = 0; loadconst = 0; negate = 0; constant = '0; chainin = '0;
    coef_wr_en = 0; coef_wr_ch = 0; coef_wr_addr = 0; coef_wr_data = 0;
    model_reset();
    step(3);
    check_zero("rst");
    clr_n = 1'b1;
    step(1);

    fire();
    drain();
    check("t1_resa", 64'(resulta), 64'd9);
    check("t1_resb", 64'(resultb), 64'd54);

    wr_coef(1'b0, 3'd3, 18'sd5);
    coefmux_a = 1; coefsel_a = 3;
    fire();
    coef_wr_en = 1; coef_wr_ch = 0; coef_wr_addr = 3; coef_wr_data = 18'sd7;
    fire();
    fire();
    drain();
    check("coef_new_resa", 64'(resulta), 64'd21);
    coefmux_a = 0;
    wr_coef(1'b1, 3'd7, -18'sd2);
    coefmux_b = 1; coefsel_b = 7; sub_a = 1;
    fire();
    sub_a = 0;
    en = 1'b0;
    wr_coef(1'b1, 3'd2, 18'sd9);
    en = 1'b1;
    coefsel_b = 2;
    fire();
    coefmux_b = 0;
    drain();

    func = 2'b01; accumulate = 1;
    fire(); fire(); fire();
    loadconst = 1; constant = 64'h100;
    fire();
    loadconst = 0; accumulate = 0; negate = 1;
    fire();
    negate = 0; func = 2'b10; chainin = 64'sd1000;
    fire();
    func = 2'b11;
    fire();
    drain();
    check("func11_chain", chainout, 64'hFFFF_FFFF_FFFF_FFD3);

    func = 2'b01; loadconst = 1; constant = 64'h7FFF_FFFF_FFFF_FFF0;
    fire();
    loadconst = 0; accumulate = 1;
    fire();
    accumulate = 0;
    fire();
    loadconst = 1; negate = 1; constant = 64'h8000_0000_0000_0010;
    fire();
    loadconst = 0; negate = 0;
    fire();
    drain();
    check("ovf_cleared", 64'(overflow), 64'd0);
    check("after_sat_chain", chainout, 64'd63);

    accumulate = 1;
    fire(); fire();
    en = 1'b0;
    co_hold = chainout; ov_hold = out_valid;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("frz_chain", chainout, co_hold);
      check("frz_valid", 64'(out_valid), 64'(ov_hold));
    end
    en = 1'b1;
    fire();
    accumulate = 0;
    drain();

    fire(); fire();
    clr_n = 1'b0;
    step(1);
    sbq.delete();
    model_reset();
    check_zero("midrst");
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("no_stray_valid", 64'(out_valid), 64'd0);
    end
    func = 2'b00; coefmux_a = 1; coefsel_a = 3;
    fire();
    drain();
    check("bank_cleared_resa", 64'(resulta), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
